// File: rtl/apb_pkg.sv
// Shared constants and state encoding for the APB initiator bridge.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   // Value driven on pprot whenever no transfer has been loaded yet.
   localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for the APB bridge.
// Compiled only when APB_TIMEOUT_EN is defined; expired_o fires on the wait
// cycle that would bring the count to LIMIT (LIMIT must be at least 1).
`ifdef APB_TIMEOUT_EN
module apb_timeout_ctr #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on SETUP, step on every stalled ACCESS cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule : apb_timeout_ctr
`endif

// File: rtl/apb_master_bridge.sv
// Valid/ready request/response to APB4 initiator bridge, one transfer in flight.
// Optional ACCESS-phase timeout abort is enabled with the APB_TIMEOUT_EN macro.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = APB_ADDR_W,
   parameter int unsigned DATA_W         = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_write,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [2:0]          req_prot,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic                out_psel,
   output logic                out_penable,
   output logic [2:0]          out_pprot,
   output logic                out_pwrite,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   input  logic                out_pready,
   input  logic [DATA_W-1:0]   out_prdata,
   input  logic                out_pslverr
);

   localparam int unsigned STRB_W = DATA_W / 8;

   apb_state_e          state_q,  state_d;
   logic [ADDR_W-1:0]   paddr_q,  paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q,  pstrb_d;
   logic [2:0]          pprot_q,  pprot_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic                err_q,    err_d;
   logic                timeout_hit;

`ifdef APB_TIMEOUT_EN
   apb_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (state_q == ST_SETUP),
      .enable_i  ((state_q == ST_ACCESS) && !out_pready),
      .expired_o (timeout_hit)
   );
`else
   // Without the counter a stalled slave is waited on forever.
   assign timeout_hit = 1'b0;
`endif

   // Next-state and next-register logic for the transfer FSM.
   // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      pprot_d  = pprot_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               paddr_d  = req_addr;
               pwrite_d = req_write;
               pwdata_d = req_wdata;
               pstrb_d  = req_write ? req_wstrb : '0;
               pprot_d  = req_prot;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A completing slave takes priority over a timeout on the same edge.
            if (out_pready) begin
               rdata_d  = pwrite_q ? '0 : out_prdata;
               err_d    = out_pslverr;
               pwrite_d = 1'b0;
               pstrb_d  = '0;
               state_d  = ST_RESP;
            end else if (timeout_hit) begin
               rdata_d  = '0;
               err_d    = 1'b1;
               pwrite_d = 1'b0;
               pstrb_d  = '0;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         pprot_q  <= APB_PPROT_DEFAULT;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         pprot_q  <= pprot_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign resp_valid  = (state_q == ST_RESP);
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;
   assign out_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign out_penable = (state_q == ST_ACCESS);
   assign out_paddr   = paddr_q;
   assign out_pwrite  = pwrite_q;
   assign out_pwdata  = pwdata_q;
   assign out_pstrb   = pstrb_q;
   assign out_pprot   = pprot_q;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a table of single transfers plus
// hand-written sequences for backpressure, stalls/timeout and mid-transfer reset.
module tb_apb_master_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic [2:0]  req_prot;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] out_paddr;
   logic        out_psel;
   logic        out_penable;
   logic [2:0]  out_pprot;
   logic        out_pwrite;
   logic [31:0] out_pwdata;
   logic [3:0]  out_pstrb;
   logic        out_pready;
   logic [31:0] out_prdata;
   logic        out_pslverr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   apb_master_bridge #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .req_wstrb   (req_wstrb),
      .req_prot    (req_prot),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .out_paddr   (out_paddr),
      .out_psel    (out_psel),
      .out_penable (out_penable),
      .out_pprot   (out_pprot),
      .out_pwrite  (out_pwrite),
      .out_pwdata  (out_pwdata),
      .out_pstrb   (out_pstrb),
      .out_pready  (out_pready),
      .out_prdata  (out_prdata),
      .out_pslverr (out_pslverr)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] prdata;
      logic        pslverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_pstrb;
      int          exp_lat;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [2:0] prot);
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = write;
      req_wdata = wdata;
      req_wstrb = wstrb;
      req_prot  = prot;
   endtask

   // One full transfer from a table entry; returns back in IDLE.
   task automatic run_vec(input int i, input vec_t v);
      int acc_cyc;
      @(negedge clock);
      out_pready = 1'b0;
      drive_req(v.addr, v.write, v.wdata, v.wstrb, v.prot);
      check($sformatf("v%0d req_ready idle", i), req_ready, 1);
      @(negedge clock);
      req_valid = 1'b0;
      acc_cyc   = cyc;
      check($sformatf("v%0d setup psel", i), out_psel, 1);
      check($sformatf("v%0d setup penable", i), out_penable, 0);
      check($sformatf("v%0d setup paddr", i), out_paddr, v.addr);
      check($sformatf("v%0d setup pwrite", i), out_pwrite, v.write);
      check($sformatf("v%0d setup pwdata", i), out_pwdata, v.wdata);
      check($sformatf("v%0d setup pstrb", i), out_pstrb, v.exp_pstrb);
      check($sformatf("v%0d setup pprot", i), out_pprot, v.prot);
      check($sformatf("v%0d setup req_ready", i), req_ready, 0);
      for (int w = 0; w <= v.waits; w++) begin
         @(negedge clock);
         check($sformatf("v%0d access%0d psel", i, w), out_psel, 1);
         check($sformatf("v%0d access%0d penable", i, w), out_penable, 1);
         check($sformatf("v%0d access%0d paddr", i, w), out_paddr, v.addr);
         check($sformatf("v%0d access%0d pwdata", i, w), out_pwdata, v.wdata);
         check($sformatf("v%0d access%0d pstrb", i, w), out_pstrb, v.exp_pstrb);
         check($sformatf("v%0d access%0d resp_valid", i, w), resp_valid, 0);
         // Wait cycles carry decoy data/error that must not be sampled.
         out_pready  = (w == v.waits);
         out_prdata  = (w == v.waits) ? v.prdata : ~v.prdata;
         out_pslverr = (w == v.waits) ? v.pslverr : ~v.pslverr;
      end
      @(negedge clock);
      out_pready  = 1'b0;
      out_pslverr = 1'b0;
      check($sformatf("v%0d resp_valid", i), resp_valid, 1);
      check($sformatf("v%0d resp_rdata", i), resp_rdata, v.exp_rdata);
      check($sformatf("v%0d resp_err", i), resp_err, v.exp_err);
      check($sformatf("v%0d latency", i), 64'(cyc - acc_cyc + 1), 64'(v.exp_lat));
      check($sformatf("v%0d resp psel", i), out_psel, 0);
      check($sformatf("v%0d resp penable", i), out_penable, 0);
      check($sformatf("v%0d resp pwrite", i), out_pwrite, 0);
      check($sformatf("v%0d resp pstrb", i), out_pstrb, 0);
      check($sformatf("v%0d resp req_ready", i), req_ready, 0);
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check($sformatf("v%0d done resp_valid", i), resp_valid, 0);
      check($sformatf("v%0d done req_ready", i), req_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{addr: 32'h1000_2004, write: 1'b0, wdata: 32'h0, wstrb: 4'hF, prot: 3'b010,
                  waits: 0, prdata: 32'h0000_A5A5, pslverr: 1'b0,
                  exp_rdata: 32'h0000_A5A5, exp_err: 1'b0, exp_pstrb: 4'h0, exp_lat: 3};
      vecs[1] = '{addr: 32'h1000_2008, write: 1'b1, wdata: 32'h1234_5678, wstrb: 4'b0011, prot: 3'b000,
                  waits: 3, prdata: 32'hDEAD_BEEF, pslverr: 1'b0,
                  exp_rdata: 32'h0, exp_err: 1'b0, exp_pstrb: 4'b0011, exp_lat: 6};
      vecs[2] = '{addr: 32'h1000_2010, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, prot: 3'b001,
                  waits: 1, prdata: 32'hCAFE_F00D, pslverr: 1'b1,
                  exp_rdata: 32'hCAFE_F00D, exp_err: 1'b1, exp_pstrb: 4'h0, exp_lat: 4};
      vecs[3] = '{addr: 32'h1000_2013, write: 1'b1, wdata: 32'h89AB_CDEF, wstrb: 4'b1100, prot: 3'b101,
                  waits: 0, prdata: 32'h1111_2222, pslverr: 1'b1,
                  exp_rdata: 32'h0, exp_err: 1'b1, exp_pstrb: 4'b1100, exp_lat: 3};

      reset       = 1'b1;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_write   = 1'b0;
      req_wdata   = '0;
      req_wstrb   = '0;
      req_prot    = '0;
      resp_ready  = 1'b0;
      out_pready  = 1'b0;
      out_prdata  = '0;
      out_pslverr = 1'b0;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst psel", out_psel, 0);
      check("rst penable", out_penable, 0);
      check("rst paddr", out_paddr, 0);
      check("rst pwdata", out_pwdata, 0);
      check("rst pwrite", out_pwrite, 0);
      check("rst pstrb", out_pstrb, 0);
      check("rst pprot", out_pprot, 0);
      check("rst resp_valid", resp_valid, 0);
      check("rst resp_rdata", resp_rdata, 0);
      check("rst resp_err", resp_err, 0);
      reset = 1'b0;
      @(negedge clock);
      check("post-rst req_ready", req_ready, 1);

      // Table of single transfers.
      for (int i = 0; i < 4; i++) begin
         run_vec(i, vecs[i]);
      end

      // Response backpressure with a competing request held valid.
      @(negedge clock);
      drive_req(32'h1000_2020, 1'b0, 32'h0, 4'h0, 3'b000);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      out_pready = 1'b1;
      out_prdata = 32'h5A5A_0001;
      @(negedge clock);
      out_pready = 1'b0;
      out_prdata = 32'hFFFF_FFFF;
      drive_req(32'h2000_0000, 1'b1, 32'hAAAA_5555, 4'hF, 3'b111);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d resp_valid", k), resp_valid, 1);
         check($sformatf("bp%0d resp_rdata", k), resp_rdata, 32'h5A5A_0001);
         check($sformatf("bp%0d req_ready", k), req_ready, 0);
         check($sformatf("bp%0d psel", k), out_psel, 0);
         check($sformatf("bp%0d paddr", k), out_paddr, 32'h1000_2020);
         @(negedge clock);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("bp done resp_valid", resp_valid, 0);
      check("bp done req_ready", req_ready, 1);
      check("bp done psel", out_psel, 0);

`ifdef APB_TIMEOUT_EN
      // Slave never ready: abort after 4 stalled ACCESS cycles.
      drive_req(32'h1000_2030, 1'b0, 32'h0, 4'h0, 3'b000);
      out_prdata = 32'hFFFF_FFFF;
      @(negedge clock);
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check($sformatf("to wait%0d penable", k), out_penable, 1);
         check($sformatf("to wait%0d resp_valid", k), resp_valid, 0);
      end
      @(negedge clock);
      check("to resp_valid", resp_valid, 1);
      check("to resp_err", resp_err, 1);
      check("to resp_rdata", resp_rdata, 0);
      check("to psel", out_psel, 0);
      check("to penable", out_penable, 0);
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("to done req_ready", req_ready, 1);
`else
      // Slave stalls for 20 cycles: ACCESS must simply hold.
      drive_req(32'h1000_2030, 1'b0, 32'h0, 4'h0, 3'b000);
      out_prdata = 32'hFFFF_FFFF;
      @(negedge clock);
      req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         check($sformatf("stall%0d penable", k), out_penable, 1);
         check($sformatf("stall%0d resp_valid", k), resp_valid, 0);
      end
      out_pready = 1'b1;
      out_prdata = 32'h0000_0077;
      @(negedge clock);
      out_pready = 1'b0;
      check("stall resp_valid", resp_valid, 1);
      check("stall resp_err", resp_err, 0);
      check("stall resp_rdata", resp_rdata, 32'h0000_0077);
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check("stall done req_ready", req_ready, 1);
`endif

      // Reset in the middle of a stalled ACCESS phase.
      drive_req(32'h1000_3000, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b011);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check("mid access penable", out_penable, 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mid-rst psel", out_psel, 0);
      check("mid-rst penable", out_penable, 0);
      check("mid-rst resp_valid", resp_valid, 0);
      check("mid-rst paddr", out_paddr, 0);
      check("mid-rst pwrite", out_pwrite, 0);
      check("mid-rst pstrb", out_pstrb, 0);
      check("mid-rst resp_rdata", resp_rdata, 0);
      reset      = 1'b0;
      out_pready = 1'b1;
      @(negedge clock);
      check("after mid-rst req_ready", req_ready, 1);
      @(negedge clock);
      out_pready = 1'b0;
      check("after mid-rst no resp", resp_valid, 0);
      check("after mid-rst psel", out_psel, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_apb_master_bridge

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready request/response interface into APB4 initiator transactions.
- The CPU-side LSU or a DMA engine issues single-beat reads and writes.
- The bridge drives the APB peripheral bus (GPIO, UART, SPI slaves) and returns read data and error status.
- One outstanding transaction; no pipelining across APB transfers.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (strobe width = DATA_W/8)
TIMEOUT_CYCLES, 255, max ACCESS-phase wait cycles before abort (only with APB_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  bridge can accept request
req_addr  in  ADDR_W  byte address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  byte enables
req_prot  in  3  APB protection bits
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  read data (0 for writes)
resp_err  out  1  slave error or timeout
out_paddr  out  ADDR_W  APB address
out_psel  out  1  APB select
out_penable  out  1  APB enable
out_pprot  out  3  APB protection
out_pwrite  out  1  APB direction
out_pwdata  out  DATA_W  APB write data
out_pstrb  out  DATA_W/8  APB strobes
out_pready  in  1  slave ready
out_prdata  in  DATA_W  slave read data
out_pslverr  in  1  slave error

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All out_* signals 0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once reset is deasserted.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1 (combinational from state == IDLE).
  - On req_valid&&req_ready, register addr/write/wdata/prot into the out_* registers.
  - out_pstrb = req_write ? req_wstrb : 0. Reads always drive pstrb=0.
  - Go to SETUP.
- SETUP:
  - psel=1, penable=0. Unconditional transition to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - Stay while out_pready=0.
  - On pready=1:
    - capture resp_rdata = write ? 0 : out_prdata;
    - resp_err = out_pslverr;
    - set resp_valid=1;
    - clear psel/penable/pwrite/pstrb on the same edge;
    - go to RESP.
- RESP:
  - resp_valid=1 with resp_rdata/resp_err held stable.
  - On resp_ready, clear resp_valid and go to IDLE.
  - req_ready stays 0 throughout RESP, so there is no overlap.
- Latency:
  - Request accepted at edge N; SETUP during N..N+1; ACCESS from N+1.
  - With zero-wait slave, resp_valid is high in the cycle after edge N+2 (3 cycles accept-to-response).
  - Each slave wait state adds 1 cycle.
- paddr/pwrite/pwdata/pstrb/pprot are stable from SETUP through the final ACCESS cycle.
- out_pslverr and out_prdata are sampled only when psel&&penable&&pready.
- Reset asserted in any state: the next edge forces IDLE and all outputs to reset values. The in-flight transfer is abandoned with no response.
- out_paddr is passed unmodified (no alignment); the slave decodes the word address.
- A new request cannot be accepted until the previous response has been consumed.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on SETUP entry and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer is aborted: psel/penable drop, RESP is entered with resp_err=1 and resp_rdata=0.
  - A pready arriving on the same edge as the timeout wins (normal completion).
- Undefined:
  - No counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_pkg:
  - state encoding localparams ST_IDLE=0, ST_SETUP=1, ST_ACCESS=2, ST_RESP=3;
  - APB_PPROT_DEFAULT=3'b000;
  - width constants ADDR_W/DATA_W defaults.
- Sub-module apb_timeout_ctr:
  - inputs clear/enable; output expired.
  - Instantiated only under APB_TIMEOUT_EN.
- The FSM stays flat in the top module.

Test Plan:
- Read, zero-wait slave: req addr 0x10002004, slave returns prdata 0x0000A5A5 pready=1 -> psel high 2 cycles, penable 1 cycle, pstrb=0, resp_valid 3 cycles after accept, rdata 0x0000A5A5, err 0.
- Write with 3 wait states: addr 0x10002008, wdata 0x12345678, wstrb 4'b0011 -> paddr/pwdata/pstrb stable across 4 ACCESS cycles, resp_rdata=0, err=0, response 6 cycles after accept.
- Slave error: read with pslverr=1 on the pready cycle -> resp_err=1, rdata captures prdata.
- Response backpressure: resp_ready held low 5 cycles with req_valid high -> resp_valid/rdata stable, req_ready=0 throughout, no new SETUP.
- Reset mid-ACCESS: assert reset with pready=0 -> next edge psel=penable=0, resp_valid=0, req_ready=1 after reset release.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4, slave never ready -> abort after 4 ACCESS wait cycles, resp_err=1, rdata=0, psel dropped.
